uart_pkt_rx: RTL
================

# uart_pkt_rx

Packet deframer directly downstream of the UART receiver. Consumes the receiver's byte strobe and serial CRC bit stream, hunts for a start-of-frame byte, buffers a length-prefixed payload, and checks a CRC-16 computed bit-serially as bits arrive. A payload is released on a valid/ready byte stream only after its CRC checks good; bad, truncated or oversize frames are discarded and flagged.

## Interface
- `MAXLEN`, 64: payload buffer depth in bytes, power of two, 2..256.
- `TIMEOUT`, 1200: idle clocks allowed between bytes inside a frame (100 µs at 12 MHz).
- `SOF`, 8'hA5: start-of-frame byte value.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `rx_data` in 8: received byte, valid when `rx_ready` is high.
- `rx_ready` in 1: one-cycle byte strobe from the UART receiver.
- `crc_din` in 1: received bit, wire order (LSB first).
- `crc_en` in 1: qualifies `crc_din`, one cycle per data bit.
- `out_data` out 8: payload byte.
- `out_valid` out 1: `out_data` is valid.
- `out_last` out 1: the current byte is the final byte of the packet.
- `out_ready` in 1: the consumer accepts the byte.
- `pkt_ok` out 1: one-cycle pulse when a frame passes CRC.
- `crc_err` out 1: one-cycle pulse when a frame fails CRC.
- `len_err` out 1: one-cycle pulse when LEN is 0 or greater than `MAXLEN`.
- `timeout_err` out 1: one-cycle pulse when the frame is abandoned on timeout.
- `overrun` out 1: one-cycle pulse when a byte is dropped during DRAIN.

## Operation
- Frame format: `SOF`, `LEN` (1..`MAXLEN`), `LEN` payload bytes, CRC low byte, CRC high byte.
- CRC is CRC-16/MCRF4XX:
  - reflected polynomial 0x8408, init 0xFFFF, no final XOR;
  - per `crc_en`: fb = crc[0]^crc_din; crc = (crc>>1) ^ (fb ? 0x8408 : 0).
  - crc is loaded with 0xFFFF on the `rx_ready` of the LEN byte, so it covers payload plus both CRC bytes.
  - A good frame leaves crc == 0 after the last CRC bit.
  - If `rx_ready` and `crc_en` coincide, the load wins and the bit is discarded. The upstream receiver never produces this case.
- States:
  - HUNT: `rx_ready` with `rx_data`==`SOF` -> LEN. Any other byte is ignored.
  - LEN: byte 0 or greater than `MAXLEN` -> pulse `len_err`, -> HUNT. Otherwise latch LEN, write pointer = 0, -> DATA.
  - DATA: each byte is written to buffer[wptr], wptr++. After the LEN-th byte -> CRCLO.
  - CRCLO: on byte -> CRCHI.
  - CRCHI: on byte, evaluate crc. If 0: pulse `pkt_ok`, read pointer = 0, -> DRAIN. Otherwise pulse `crc_err`, -> HUNT.
  - DRAIN: present buffer[rptr]. A transfer (`out_valid`&`out_ready`) increments rptr. The transfer with `out_last` -> HUNT.
- `SOF` bytes inside LEN..CRCHI are ordinary data; there is no resync mid-frame.
- Timeout:
  - The counter clears on every `rx_ready` and counts in LEN, DATA, CRCLO and CRCHI.
  - Reaching `TIMEOUT` pulses `timeout_err` and returns to HUNT.
  - The counter does not run in HUNT or DRAIN.
- Any `rx_ready` during DRAIN pulses `overrun`; the byte is discarded and the block stays in DRAIN.
- Reset (`rst_n`=0 at a clock edge):
  - state HUNT, crc 0xFFFF, pointers and timeout counter 0.
  - `out_valid`, `out_last` and all pulse outputs are 0; `out_data` is 0.
  - A frame or drain in progress is abandoned.

## Timing
- Byte-strobe actions (state change, buffer write, latch) take effect on the clock edge that samples `rx_ready`.
- `rx_ready` of the CRC high byte at edge T -> `pkt_ok`/`crc_err` high T+1..T+2.
- For a good frame, `out_valid` is high from T+1 with `out_data`=byte 0.
- Exactly one payload byte transfers per `out_valid`&`out_ready` cycle; back-to-back transfers sustain 1 byte/clock.
- `out_data` and `out_last` hold while `out_valid`&!`out_ready`. `out_valid` never drops before the last transfer.
- `out_valid` falls the cycle after the `out_last` transfer. A new frame can start (HUNT) that same cycle.
- `len_err` and `timeout_err` pulse one cycle after the causing edge.

## Configuration
- `UART_PKT_RX_STATS_EN`:
  - Defined: adds outputs `stat_ok`, `stat_crc`, `stat_len`, `stat_tmo` and `stat_ovr`, each 8-bit.
  - Each counter saturates at 255, increments on its pulse, and clears on reset.
  - Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- A5 09 31 32 33 34 35 36 37 38 39 91 6F at 1 Mbaud, `out_ready`=1 -> 31..39 out on consecutive clocks, `out_last` only with 39, one `pkt_ok`, no errors.
- Same frame with payload byte 35 changed to 36 -> one `crc_err`, `out_valid` never high, next good frame accepted.
- A5 00, then A5 with LEN=`MAXLEN`+1 -> two `len_err` pulses, returns to HUNT each time.
- A5 09 31 32, then silence for `TIMEOUT` clocks -> `timeout_err` pulse; a following good frame passes.
- Good frame with `out_ready`=0, then a second frame sent -> `out_data`=31 held, `overrun` pulse per byte of the second frame. Releasing `out_ready` drains all 9 bytes.
- Assert `rst_n`=0 mid-DATA and mid-DRAIN -> all outputs 0 next cycle, state HUNT; with `UART_PKT_RX_STATS_EN` all counters read 0.

Source files
------------

// File: rtl/uart_pkt_rx.sv
// uart_pkt_rx: SOF/LEN packet deframer with bit-serial CRC-16/MCRF4XX.
// Ports: clk, rst_n (sync, active low), rx_data/rx_ready byte strobe,
// crc_din/crc_en serial bits, out_data/out_valid/out_last/out_ready
// payload stream, pkt_ok/crc_err/len_err/timeout_err/overrun pulses.
// Optional UART_PKT_RX_STATS_EN adds saturating 8-bit stat_* counters.
module uart_pkt_rx #(
  parameter int          MAXLEN  = 64,
  parameter int          TIMEOUT = 1200,
  parameter logic [7:0]  SOF     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       crc_din,
  input  logic       crc_en,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
`ifdef UART_PKT_RX_STATS_EN
  output logic [7:0] stat_ok,
  output logic [7:0] stat_crc,
  output logic [7:0] stat_len,
  output logic [7:0] stat_tmo,
  output logic [7:0] stat_ovr,
`endif
  output logic       pkt_ok,
  output logic       crc_err,
  output logic       len_err,
  output logic       timeout_err,
  output logic       overrun
);

  localparam int PW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_HUNT, S_LEN, S_DATA, S_CRCLO, S_CRCHI, S_DRAIN
  } state_t;

  state_t        state, state_n;
  logic [15:0]   crc;
  logic [7:0]    len, wptr, rptr;
  logic [TW-1:0] tcnt;
  logic [7:0]    mem [MAXLEN];

  logic in_frame, tmo_hit;
  logic ok_n, crc_n, len_n, tmo_n, ovr_n;
  logic xfer;

  assign in_frame  = (state == S_LEN) || (state == S_DATA) ||
                     (state == S_CRCLO) || (state == S_CRCHI);
  assign out_valid = (state == S_DRAIN);
  assign out_last  = out_valid && (rptr == len - 8'd1);
  assign out_data  = out_valid ? mem[rptr[PW-1:0]] : 8'h00;
  assign xfer      = out_valid && out_ready;

  always_comb begin
    state_n = state;
    ok_n    = 1'b0;
    crc_n   = 1'b0;
    len_n   = 1'b0;
    tmo_n   = 1'b0;
    ovr_n   = 1'b0;
    tmo_hit = in_frame && !rx_ready &&
              (tcnt == TW'(TIMEOUT - 1));
    unique case (state)
      S_HUNT:
        if (rx_ready && rx_data == SOF) state_n = S_LEN;
      S_LEN:
        if (rx_ready) begin
          if (rx_data == 8'd0 ||
              {1'b0, rx_data} > 9'(MAXLEN)) begin
            len_n   = 1'b1;
            state_n = S_HUNT;
          end else begin
            state_n = S_DATA;
          end
        end
      S_DATA:
        if (rx_ready && wptr == len - 8'd1) state_n = S_CRCLO;
      S_CRCLO:
        if (rx_ready) state_n = S_CRCHI;
      S_CRCHI:
        if (rx_ready) begin
          if (crc == 16'h0000) begin
            ok_n    = 1'b1;
            state_n = S_DRAIN;
          end else begin
            crc_n   = 1'b1;
            state_n = S_HUNT;
          end
        end
      S_DRAIN: begin
        ovr_n = rx_ready;
        if (xfer && out_last) state_n = S_HUNT;
      end
      default: state_n = S_HUNT;
    endcase
    if (tmo_hit) begin
      tmo_n   = 1'b1;
      state_n = S_HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_HUNT;
      crc         <= 16'hFFFF;
      len         <= 8'd0;
      wptr        <= 8'd0;
      rptr        <= 8'd0;
      tcnt        <= '0;
      pkt_ok      <= 1'b0;
      crc_err     <= 1'b0;
      len_err     <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      pkt_ok      <= ok_n;
      crc_err     <= crc_n;
      len_err     <= len_n;
      timeout_err <= tmo_n;
      overrun     <= ovr_n;
      // LEN strobe seeds the CRC; a coincident bit is dropped
      if (rx_ready && state == S_LEN)
        crc <= 16'hFFFF;
      else if (crc_en)
        crc <= {1'b0, crc[15:1]} ^
               ((crc[0] ^ crc_din) ? 16'h8408 : 16'h0000);
      if (rx_ready && state == S_LEN) begin
        len  <= rx_data;
        wptr <= 8'd0;
      end
      if (rx_ready && state == S_DATA)
        wptr <= wptr + 8'd1;
      if (rx_ready && state == S_CRCHI)
        rptr <= 8'd0;
      else if (xfer)
        rptr <= rptr + 8'd1;
      if (rx_ready || !in_frame || tmo_hit)
        tcnt <= '0;
      else
        tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && rx_ready && state == S_DATA)
      mem[wptr[PW-1:0]] <= rx_data;
  end

`ifdef UART_PKT_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ok  <= 8'd0;
      stat_crc <= 8'd0;
      stat_len <= 8'd0;
      stat_tmo <= 8'd0;
      stat_ovr <= 8'd0;
    end else begin
      if (pkt_ok && stat_ok != 8'hFF)
        stat_ok <= stat_ok + 8'd1;
      if (crc_err && stat_crc != 8'hFF)
        stat_crc <= stat_crc + 8'd1;
      if (len_err && stat_len != 8'hFF)
        stat_len <= stat_len + 8'd1;
      if (timeout_err && stat_tmo != 8'hFF)
        stat_tmo <= stat_tmo + 8'd1;
      if (overrun && stat_ovr != 8'hFF)
        stat_ovr <= stat_ovr + 8'd1;
    end
  end
`endif

endmodule
